// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Ripple-carry adder split into STAGES equal slices of SW = WIDTH/STAGES
//   bits. Each stage adds one slice and registers the carry for the next one,
//   so a result appears STAGES cycles after its operands are accepted.
//   WIDTH must be a multiple of STAGES.
//
//   Optional feature (macro PIPELINED_ADDER_OVF_EN): adds output ovf, the
//   signed two's-complement overflow flag, timed and held exactly like sum.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands a/b/cin valid this cycle
//   in_ready   block accepts operands this cycle (combinational)
//   a, b       WIDTH-bit unsigned operands
//   cin        carry in
//   out_valid  sum/cout (and ovf) valid
//   out_ready  downstream accepts the result
//   sum        low WIDTH bits of a+b+cin
//   cout       bit WIDTH of a+b+cin
//   ovf        signed overflow (only with PIPELINED_ADDER_OVF_EN)
//
// Handshake: a word moves on a rising edge where valid && ready are both 1.
// The whole pipeline advances together (adv = !out_valid || out_ready) and
// in_ready equals adv, so a stalled output freezes every stage, valid bits
// included, and the source must hold its operands until accepted.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int SW = WIDTH / STAGES;

  logic w_adv;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage k holds the operand bits not yet consumed ([WIDTH-1 : k*SW] of the
  // original), the carry into slice k, the partial sum built so far and a
  // valid bit. Its combinational adder produces slice k for stage k+1.
  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int RW = WIDTH - k * SW;

    logic [RW-1:0]    w_a_in, w_b_in, r_a, r_b;
    logic             w_c_in, r_c, w_v_in, r_v;
    logic [WIDTH-1:0] w_acc_in, r_acc, w_acc_out;
    logic [SW:0]      w_add;

    if (k == 0) begin : gen_head
      assign w_a_in   = a;
      assign w_b_in   = b;
      assign w_c_in   = cin;
      assign w_acc_in = '0;
      assign w_v_in   = in_valid;
    end else begin : gen_link
      // Drop the slice the previous stage already consumed.
      assign w_a_in   = gen_stage[k-1].r_a[RW+SW-1:SW];
      assign w_b_in   = gen_stage[k-1].r_b[RW+SW-1:SW];
      assign w_c_in   = gen_stage[k-1].w_add[SW];
      assign w_acc_in = gen_stage[k-1].w_acc_out;
      assign w_v_in   = gen_stage[k-1].r_v;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_c   <= 1'b0;
        r_acc <= '0;
      end else if (w_adv) begin
        r_v   <= w_v_in;
        r_a   <= w_a_in;
        r_b   <= w_b_in;
        r_c   <= w_c_in;
        r_acc <= w_acc_in;
      end
    end

    assign w_add = {1'b0, r_a[SW-1:0]} + {1'b0, r_b[SW-1:0]} + {{SW{1'b0}}, r_c};

    always_comb begin
      w_acc_out = r_acc;
      w_acc_out[k*SW +: SW] = w_add[SW-1:0];
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic w_msb_cin;
  logic w_ovf;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
  assign w_msb_cin = gen_stage[STAGES-1].r_a[SW-1] ^ gen_stage[STAGES-1].r_b[SW-1] ^
                     gen_stage[STAGES-1].w_add[SW-1];
  assign w_ovf     = w_msb_cin ^ gen_stage[STAGES-1].w_add[SW];
`endif

  // Output register: finishes the last slice; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (w_adv) begin
      out_valid <= gen_stage[STAGES-1].r_v;
      sum       <= gen_stage[STAGES-1].w_acc_out;
      cout      <= gen_stage[STAGES-1].w_add[SW];
`ifdef PIPELINED_ADDER_OVF_EN
      ovf       <= w_ovf;
`endif
    end
  end

endmodule
